// File: rtl/ssd_scan_scheduler.sv
// Scan scheduler for a 4-digit seven-segment display: frame-synchronous value
// commit, leading-zero suppression, per-digit blink, registered anode/nibble drive.
module ssd_scan_scheduler #(
  parameter int unsigned SCAN_DIV     = 200000,
  parameter int unsigned BLINK_FRAMES = 125
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] in_value,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        lz_en,
  input  logic [3:0]  blink_mask,
  output logic [3:0]  Anodes,
  output logic [3:0]  digit,
  output logic        frame_start
);

  localparam int unsigned DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned BLK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_PEND = 1'b1;

  logic [DIV_W-1:0] r_div_cnt;
  logic [1:0]       r_idx;
  logic [15:0]      r_disp;
  logic [15:0]      r_pend;
  logic [0:0]       r_state;
  logic             r_ready;
  logic [BLK_W-1:0] r_blink_cnt;
  logic             r_blink_phase;
  logic [3:0]       r_anodes;
  logic [3:0]       r_digit;
  logic             r_frame_start;

  logic             w_tick;
  logic             w_frame_end;
  logic             w_blink_wrap;
  logic [0:0]       w_state_nxt;
  logic             w_accept;
  logic             w_commit;
  logic [3:0]       w_nibble;
  logic [3:0]       w_lz_zero;
  logic             w_lz_blank;
  logic             w_blink_blank;
  logic             w_blank;
  logic [3:0]       w_anodes_nxt;
  logic [3:0]       w_digit_nxt;
  logic             w_frame_start_nxt;

  assign w_tick       = (r_div_cnt == DIV_W'(SCAN_DIV - 1));
  assign w_frame_end  = w_tick && (r_idx == 2'd3);
  assign w_blink_wrap = w_frame_end && (r_blink_cnt == BLK_W'(BLINK_FRAMES - 1));

  // Slot divider and digit index.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_div_cnt <= '0;
      r_idx     <= 2'd0;
    end else begin
      r_div_cnt <= w_tick ? '0 : r_div_cnt + DIV_W'(1);
      if (w_tick) begin
        r_idx <= r_idx + 2'd1;
      end
    end
  end

  // Handshake state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_ready <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_ready <= (w_state_nxt == S_IDLE);
    end
  end

  // Next state: an accept on the frame_end cycle defers commit to the next frame.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_commit    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = S_PEND;
        end
      end
      S_PEND: begin
        if (w_frame_end) begin
          w_commit    = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Pending and displayed value holding registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_pend <= 16'h0000;
      r_disp <= 16'h0000;
    end else begin
      if (w_accept) begin
        r_pend <= in_value;
      end
      if (w_commit) begin
        r_disp <= r_pend;
      end
    end
  end

  // Blink half-period counter, advanced once per completed frame.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b0;
    end else if (w_frame_end) begin
      if (w_blink_wrap) begin
        r_blink_cnt   <= '0;
        r_blink_phase <= ~r_blink_phase;
      end else begin
        r_blink_cnt <= r_blink_cnt + BLK_W'(1);
      end
    end
  end

  // Nibble select and blanking for the current slot.
  always_comb begin
    w_nibble = 4'h0;
    case (r_idx)
      2'd0:    w_nibble = r_disp[15:12];
      2'd1:    w_nibble = r_disp[11:8];
      2'd2:    w_nibble = r_disp[7:4];
      default: w_nibble = r_disp[3:0];
    endcase
  end

  // Digit i is a leading zero when it and every digit to its left are zero.
  assign w_lz_zero[0] = (r_disp[15:12] == 4'h0);
  assign w_lz_zero[1] = w_lz_zero[0] && (r_disp[11:8] == 4'h0);
  assign w_lz_zero[2] = w_lz_zero[1] && (r_disp[7:4] == 4'h0);
  assign w_lz_zero[3] = 1'b0;

  assign w_lz_blank    = lz_en && w_lz_zero[r_idx];
  assign w_blink_blank = r_blink_phase && blink_mask[~r_idx];
  assign w_blank       = w_lz_blank || w_blink_blank;

  always_comb begin
    w_anodes_nxt      = 4'b1111;
    w_digit_nxt       = 4'h0;
    w_frame_start_nxt = (r_idx == 2'd0) && (r_div_cnt == '0);
    if (!w_blank) begin
      w_anodes_nxt = ~(4'b1000 >> r_idx);
      w_digit_nxt  = w_nibble;
    end
  end

  // Output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_anodes      <= 4'b1111;
      r_digit       <= 4'h0;
      r_frame_start <= 1'b0;
    end else begin
      r_anodes      <= w_anodes_nxt;
      r_digit       <= w_digit_nxt;
      r_frame_start <= w_frame_start_nxt;
    end
  end

  assign in_ready    = r_ready;
  assign Anodes      = r_anodes;
  assign digit       = r_digit;
  assign frame_start = r_frame_start;

endmodule

// File: tb/tb_ssd_scan_scheduler.sv
// Directed bench for ssd_scan_scheduler with a cycle-count based reference model
// compared on every cycle, plus hand-computed literal expectations.
module tb_ssd_scan_scheduler;

  localparam int unsigned SD = 4;
  localparam int unsigned BF = 2;
  localparam int unsigned FR = 4 * SD;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] in_value;
  logic        in_valid;
  logic        in_ready;
  logic        lz_en;
  logic [3:0]  blink_mask;
  logic [3:0]  Anodes;
  logic [3:0]  digit;
  logic        frame_start;

  always #5 clock = ~clock;

  ssd_scan_scheduler #(.SCAN_DIV(SD), .BLINK_FRAMES(BF)) dut (
    .clock(clock), .reset(reset), .in_value(in_value), .in_valid(in_valid),
    .in_ready(in_ready), .lz_en(lz_en), .blink_mask(blink_mask),
    .Anodes(Anodes), .digit(digit), .frame_start(frame_start)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: position in the scan is just the cycle count since reset.
  int          m_cyc;
  int          m_frames;
  int          m_slot;
  bit          m_valid = 1'b0;
  bit          m_pending;
  bit          m_phase;
  bit          m_fe;
  bit          m_blank;
  logic [15:0] m_disp;
  logic [15:0] m_pend;
  logic [15:0] m_upper;
  logic [3:0]  exp_an;
  logic [3:0]  exp_dig;
  logic        exp_fs;
  logic        exp_rdy;

  always @(posedge clock) begin
    if (reset) begin
      m_valid = 1'b1; m_cyc = 0; m_frames = 0; m_phase = 1'b0;
      m_pending = 1'b0; m_disp = 16'h0; m_pend = 16'h0;
      exp_an = 4'hF; exp_dig = 4'h0; exp_fs = 1'b0; exp_rdy = 1'b1;
    end else if (m_valid) begin
      m_slot  = (m_cyc / SD) % 4;
      m_upper = m_disp >> (12 - 4 * m_slot);
      m_blank = (lz_en && m_slot < 3 && m_upper == 16'h0) ||
                (m_phase && blink_mask[3 - m_slot]);
      exp_an  = m_blank ? 4'hF : (4'hF ^ (4'h1 << (3 - m_slot)));
      exp_dig = m_blank ? 4'h0 : m_upper[3:0];
      exp_fs  = ((m_cyc % FR) == 0);
      m_fe    = ((m_cyc % FR) == FR - 1);
      if (m_pending && m_fe) begin
        m_disp = m_pend; m_pending = 1'b0;
      end else if (!m_pending && in_valid) begin
        m_pend = in_value; m_pending = 1'b1;
      end
      if (m_fe) begin
        m_frames++;
        m_phase = (((m_frames / BF) % 2) == 1);
      end
      exp_rdy = !m_pending;
      m_cyc++;
    end
  end

  always @(negedge clock) begin
    if (m_valid) begin
      chk("model_anodes", Anodes, exp_an);
      chk("model_digit", digit, exp_dig);
      chk("model_frame_start", frame_start, exp_fs);
      chk("model_in_ready", in_ready, exp_rdy);
    end
  end

  // Advance to the first observed cycle of slot k (outputs of edge m_cyc-1).
  task automatic wait_slot(input int k);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 64 && !found; i++) begin
      @(negedge clock);
      if (((m_cyc - 1) % FR) == SD * k) found = 1'b1;
    end
    if (!found) chk("timeout_wait_slot", 16'd0, 16'd1);
  endtask

  task automatic wait_ready;
    bit found;
    found = 1'b0;
    for (int i = 0; i < 80 && !found; i++) begin
      @(negedge clock);
      if (in_ready === 1'b1) found = 1'b1;
    end
    if (!found) chk("timeout_wait_ready", 16'd0, 16'd1);
  endtask

  // Offer a value for one cycle and wait until it has been committed.
  task automatic send(input logic [15:0] v);
    in_valid = 1'b1; in_value = v;
    @(negedge clock);
    in_valid = 1'b0; in_value = 16'hDEAD;
    wait_ready();
  endtask

  bit lit0 [8];
  int lit_cnt;

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_value = 16'h0; lz_en = 1'b0; blink_mask = 4'h0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    chk("rst_anodes", Anodes, 4'hF);
    chk("rst_digit", digit, 4'h0);
    chk("rst_ready", in_ready, 1'b1);

    // Idle scan from reset
    @(negedge clock);
    chk("t1_an_slot0", Anodes, 4'h7);
    chk("t1_fs_first", frame_start, 1'b1);
    repeat (4) @(negedge clock);
    chk("t1_an_slot1", Anodes, 4'hB);
    chk("t1_fs_off", frame_start, 1'b0);
    repeat (12) @(negedge clock);
    chk("t1_an_wrap", Anodes, 4'h7);
    chk("t1_fs_second", frame_start, 1'b1);
    repeat (15) @(negedge clock);

    // Mid-frame offer of 0x1A3F
    while ((m_cyc % FR) != 6) @(negedge clock);
    in_valid = 1'b1; in_value = 16'h1A3F;
    @(negedge clock);
    in_valid = 1'b0;
    chk("t2_ready_low", in_ready, 1'b0);
    wait_slot(2);
    chk("t2_old_value", digit, 4'h0);
    wait_ready();
    wait_slot(0); chk("t2_d0", digit, 4'h1); chk("t2_a0", Anodes, 4'h7);
    wait_slot(1); chk("t2_d1", digit, 4'hA);
    wait_slot(2); chk("t2_d2", digit, 4'h3);
    wait_slot(3); chk("t2_d3", digit, 4'hF); chk("t2_a3", Anodes, 4'hE);

    // Leading-zero suppression
    lz_en = 1'b1;
    send(16'h0040);
    wait_slot(0); chk("t3_a0", Anodes, 4'hF); chk("t3_d0", digit, 4'h0);
    wait_slot(1); chk("t3_a1", Anodes, 4'hF);
    wait_slot(2); chk("t3_a2", Anodes, 4'hD); chk("t3_d2", digit, 4'h4);
    wait_slot(3); chk("t3_a3", Anodes, 4'hE); chk("t3_d3", digit, 4'h0);
    send(16'h0000);
    wait_slot(0); chk("t3z_a0", Anodes, 4'hF);
    wait_slot(2); chk("t3z_a2", Anodes, 4'hF);
    wait_slot(3); chk("t3z_a3", Anodes, 4'hE); chk("t3z_d3", digit, 4'h0);

    // Blink on digit0
    lz_en = 1'b0; blink_mask = 4'b1000;
    send(16'h1234);
    lit_cnt = 0;
    for (int f = 0; f < 8; f++) begin
      wait_slot(0);
      lit0[f] = (Anodes == 4'h7);
      if (lit0[f]) begin
        lit_cnt++;
        chk("t4_d0_lit", digit, 4'h1);
      end else begin
        chk("t4_d0_blank", digit, 4'h0);
      end
      wait_slot(1); chk("t4_a1", Anodes, 4'hB); chk("t4_d1", digit, 4'h2);
    end
    chk("t4_lit_count", 16'(lit_cnt), 16'd4);
    for (int f = 0; f < 6; f++) chk("t4_period", 16'(lit0[f] ^ lit0[f+2]), 16'd1);
    blink_mask = 4'h0;

    // Offer exactly on frame_end; second offer while pending is ignored
    while ((m_cyc % FR) != FR - 1) @(negedge clock);
    in_valid = 1'b1; in_value = 16'hBEEF;
    @(negedge clock);
    chk("t5_ready_low", in_ready, 1'b0);
    in_value = 16'h5555;
    @(negedge clock);
    chk("t5_no_early_a", Anodes, 4'h7);
    chk("t5_no_early_d", digit, 4'h1);
    repeat (2) @(negedge clock);
    in_valid = 1'b0;
    wait_ready();
    wait_slot(0); chk("t5_d0", digit, 4'hB);
    wait_slot(1); chk("t5_d1", digit, 4'hE);
    wait_slot(3); chk("t5_d3", digit, 4'hF);
    wait_slot(0); chk("t5_kept", digit, 4'hB); chk("t5_ready", in_ready, 1'b1);

    // Reset while a value is pending
    in_valid = 1'b1; in_value = 16'h7777;
    @(negedge clock);
    in_valid = 1'b0;
    chk("t6_pending", in_ready, 1'b0);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("t6_rst_an", Anodes, 4'hF);
    chk("t6_rst_dig", digit, 4'h0);
    @(negedge clock);
    chk("t6_restart_an", Anodes, 4'h7);
    chk("t6_restart_fs", frame_start, 1'b1);
    chk("t6_restart_dig", digit, 4'h0);
    repeat (2) wait_slot(0);
    chk("t6_lost_dig", digit, 4'h0);
    chk("t6_ready", in_ready, 1'b1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

endmodule
